demux16_deser: RTL and testbench
================================

# demux16_deser

Serial-to-parallel deserializer: the receive-side counterpart of the 16-to-1 mux serializer. It accepts one bit per handshake on `In` and steers bit k of each frame into `Out[k]`, the same index order the mux select walks (0 first, 15 last). It assembles 16-bit words behind a one-word output holding register, so one frame can fill while the previous word waits to be taken. It sits between a serial link and any parallel datapath consumer.

## Interface
Parameters: none (fixed 16-bit word, matching the mux16_1 width).

- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `In` input 1: serial data bit.
- `InValid` input 1: `In` carries a bit this cycle.
- `InReady` output 1: block accepts a bit this cycle.
- `Out` output 16: assembled word, `Out[k]` = frame bit k.
- `OutValid` output 1: `Out` and `Err` hold a complete word.
- `OutReady` input 1: consumer takes the word this cycle.
- `Cnt` output 5: index of the next bit to be accepted (the mux-select equivalent).
- `Err` output 1: parity error flag for the word on `Out`; 0 when parity is compiled out.

## Operation
- Bit accept: `InValid && InReady` on a rising edge.
- Internal state: a 16-bit shift/steer register `sreg`, frame counter `Cnt`, output register `Out` with `OutValid`, and a 2-state FSM.
- On each accept, the bit goes into `sreg[Cnt]` for Cnt 0..15, and `Cnt` increments.
- Last frame bit is Cnt=15, or Cnt=16 when parity is compiled in.
- When the last bit is accepted, the word completes. `Cnt` wraps to 0.
- FSM states:
  - FILL: `InReady`=1.
  - STALL: `InReady`=0. `sreg` holds a complete word that cannot yet transfer.
- Transfer rule at word completion, or on any cycle in STALL:
  - If `!OutValid`, or `OutValid && OutReady` in the same cycle, then `sreg` (with the last bit merged) loads into `Out`, `OutValid` stays or becomes 1, and the FSM goes to or stays in FILL.
  - Otherwise, FILL → STALL, holding the word.
- STALL → FILL on the cycle `OutReady` is seen. The held word loads into `Out` and `OutValid` remains 1.
- Consume without a new word: `OutValid && OutReady` with no transfer clears `OutValid` next cycle. `Out` keeps its last value.
- `Out` and `Err` are stable while `OutValid && !OutReady`.
- `InValid` low: no state change. Gaps between bits are unlimited.

## Timing
- Reset values:
  - `Out`=16'h0000, `OutValid`=0, `Err`=0, `Cnt`=0, FSM=FILL, `sreg`=0.
  - `InReady`=1 the cycle after reset.
- `InReady` is combinational from FSM state only, with no path from `InValid`. `OutValid`, `Out`, `Err` and `Cnt` are registered.
- Latency: `OutValid` rises on the cycle after the final bit's accept edge.
- Throughput: one bit per cycle sustained while the consumer keeps `OutReady`=1. This gives back-to-back words with no bubble.
- Simultaneous completion and consume: the new word replaces the old one, and `OutValid` stays 1 without dropping.
- Worst-case backpressure: at most one complete word in `Out` plus one in `sreg`. Nothing is lost.
- Reset mid-frame or in STALL discards the partial or held words. There is no output pulse.

## Configuration
- Macro: `DEMUX16_PARITY_EN`.
- Defined:
  - Frame is 17 bits, and bit 16 is even parity over bits 0..15.
  - `Cnt` runs 0..16.
  - `Err` is registered with the word: 1 if the XOR of the 16 data bits and the parity bit is 1.
  - The word is delivered regardless of `Err`.
- Undefined:
  - Frame is 16 bits, and `Cnt[4]` is always 0.
  - `Err` is tied to 0 and no parity logic is present.

## Test plan
- Reset, then 16 accepts of bits for 16'hA5C3, LSB first, `OutReady`=1 → `OutValid`=1 one cycle after the 16th accept, `Out`=16'hA5C3, `Cnt`=0, `Err`=0.
- Two words 16'h0001 then 16'h8000 sent continuously with `OutReady`=1 → each word is valid for exactly one cycle, with no gap and no lost bit.
- `OutReady`=0 while 16'h1234 then 16'h5678 are sent → after the second word, `InReady`=0 and `Out`=16'h1234 is held. Raise `OutReady` for one cycle → `Out`=16'h5678 and `InReady`=1 the next cycle.
- `rst` asserted after 7 bits, then a full frame of 16'hFFFF → no spurious `OutValid`, and `Out`=16'hFFFF.
- `DEMUX16_PARITY_EN` defined: 16'h0003 with parity 0 → `Err`=0. 16'h0007 with parity 0 → `Err`=1 and `Out`=16'h0007.
- Random `InValid`/`OutReady` toggling over 1000 words → output sequence equals the input words in order, `Out` is stable while stalled, and `InReady` is never high in STALL.

Source files
------------

// File: rtl/demux16_deser.sv
// 16-bit serial-to-parallel deserializer with a one-word output holding register.
// Define DEMUX16_PARITY_EN for a 17-bit frame whose bit 16 is even parity, reported on Err.
module demux16_deser (
  input  logic        clk,
  input  logic        rst,
  input  logic        In,
  input  logic        InValid,
  output logic        InReady,
  output logic [15:0] Out,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [4:0]  Cnt,
  output logic        Err
);

  typedef enum logic {StFill, StStall} state_e;

`ifdef DEMUX16_PARITY_EN
  localparam logic [4:0] LastCnt = 5'd16;
`else
  localparam logic [4:0] LastCnt = 5'd15;
`endif

  state_e      state;
  logic [15:0] sreg;
  logic [15:0] sreg_merged;
  logic        accept;
  logic        last;
  logic        take;

  assign InReady = (state == StFill);
  assign accept  = InValid && InReady;
  assign last    = accept && (Cnt == LastCnt);
  // Out can be overwritten when it is empty or being consumed this same cycle.
  assign take    = !OutValid || OutReady;

  // Word as it will look once the current bit lands; the parity bit (Cnt=16) is not stored.
  always_comb begin
    sreg_merged = sreg;
    if (!Cnt[4]) begin
      sreg_merged[Cnt[3:0]] = In;
    end
  end

`ifdef DEMUX16_PARITY_EN
  logic par_q;
  logic err_q;
  logic err_new;
  logic err_held;

  assign err_new  = ^{sreg, In};
  assign err_held = ^{sreg, par_q};
  assign Err      = err_q;
`else
  assign Err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StFill;
      sreg     <= '0;
      Cnt      <= '0;
      Out      <= '0;
      OutValid <= 1'b0;
`ifdef DEMUX16_PARITY_EN
      par_q    <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else begin
      unique case (state)
        StFill: begin
          if (accept) begin
            sreg <= sreg_merged;
            Cnt  <= last ? 5'd0 : Cnt + 5'd1;
          end
          if (last && take) begin
            Out      <= sreg_merged;
            OutValid <= 1'b1;
`ifdef DEMUX16_PARITY_EN
            err_q    <= err_new;
`endif
          end else if (last) begin
            state <= StStall;
`ifdef DEMUX16_PARITY_EN
            par_q <= In;
`endif
          end else if (OutValid && OutReady) begin
            OutValid <= 1'b0;
          end
        end
        StStall: begin
          // OutValid is always set here; a consume swaps in the held word.
          if (OutReady) begin
            Out   <= sreg;
            state <= StFill;
`ifdef DEMUX16_PARITY_EN
            err_q <= err_held;
`endif
          end
        end
        default: state <= StFill;
      endcase
    end
  end

endmodule

// File: tb/tb_demux16_deser.sv
// Bench for demux16_deser: directed frames plus randomized handshakes against a queue model
// that tracks completed-but-unconsumed words.
module tb_demux16_deser;

`ifdef DEMUX16_PARITY_EN
  localparam int FRAME = 17;
`else
  localparam int FRAME = 16;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        In;
  logic        InValid;
  logic        InReady;
  logic [15:0] Out;
  logic        OutValid;
  logic        OutReady;
  logic [4:0]  Cnt;
  logic        Err;

  always #5 clk = ~clk;

  demux16_deser dut (
    .clk      (clk),
    .rst      (rst),
    .In       (In),
    .InValid  (InValid),
    .InReady  (InReady),
    .Out      (Out),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Cnt      (Cnt),
    .Err      (Err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: words completed but not yet taken, oldest first; at most two may exist.
  logic [15:0] q_word[$];
  logic        q_err[$];
  logic [15:0] last_out;
  int          bitcnt;
  logic [16:0] frame;
  bit          stream[$];
  bit          acc_last;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic check_all();
    logic [15:0] exp_out;
    logic        exp_err;
    exp_out = (q_word.size() > 0) ? q_word[0] : last_out;
    exp_err = (q_err.size() > 0) ? q_err[0] : 1'b0;
    chk("OutValid", {15'd0, OutValid}, {15'd0, q_word.size() > 0});
    chk("InReady", {15'd0, InReady}, {15'd0, q_word.size() < 2});
    chk("Out", Out, exp_out);
    chk("Cnt", {11'd0, Cnt}, bitcnt[15:0]);
    if (q_word.size() > 0) chk("Err", {15'd0, Err}, {15'd0, exp_err});
  endtask

  // Check current outputs, drive one cycle of inputs, advance the model across the edge.
  task automatic step(input bit b, input bit iv, input bit ordy);
    bit acc;
    bit cons;
    check_all();
    In       = b;
    InValid  = iv;
    OutReady = ordy;
    acc  = iv && (q_word.size() < 2);
    cons = ordy && (q_word.size() > 0);
    if (cons) begin
      last_out = q_word.pop_front();
      void'(q_err.pop_front());
    end
    if (acc) begin
      frame[bitcnt] = b;
      bitcnt++;
      if (bitcnt == FRAME) begin
        q_word.push_back(frame[15:0]);
        q_err.push_back((FRAME == 17) ? ^frame : 1'b0);
        bitcnt = 0;
      end
    end
    acc_last = acc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    InValid  = 1'b0;
    OutReady = 1'b0;
    In       = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q_word.delete();
    q_err.delete();
    last_out = 16'h0000;
    bitcnt   = 0;
    frame    = '0;
  endtask

  task automatic push_word(input logic [15:0] w, input bit par);
    for (int k = 0; k < 16; k++) stream.push_back(w[k]);
    if (FRAME == 17) stream.push_back(par);
  endtask

  // mode 0/1: InValid=1 with fixed OutReady; mode 2: both random.
  task automatic run(input int mode, input int budget);
    int  guard;
    bit  iv;
    bit  ordy;
    guard = 0;
    while (stream.size() > 0 && guard < budget) begin
      iv   = (mode == 2) ? ($urandom_range(3) != 0) : 1'b1;
      ordy = (mode == 2) ? $urandom_range(1) : (mode == 1);
      step(stream[0], iv, ordy);
      if (acc_last) void'(stream.pop_front());
      guard++;
    end
    n_checks++;
    assert (guard < budget) n_pass++;
    else $error("FAIL run_timeout: observed %0d bits left expected 0", stream.size());
    stream.delete();
  endtask

  initial begin
    logic [15:0] w;

    do_reset();
    step(1'b0, 1'b0, 1'b0);

    // Single word, consumer ready.
    push_word(16'hA5C3, 1'b0);
    run(1, 100);
    chk("a5c3_out", Out, 16'hA5C3);
    chk("a5c3_valid", {15'd0, OutValid}, 16'd1);
    step(1'b0, 1'b0, 1'b1);

    // Back-to-back words with no bubble.
    push_word(16'h0001, 1'b0);
    push_word(16'h8000, 1'b1);
    run(1, 100);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // Full backpressure: two words buffered, input stalls.
    push_word(16'h1234, 1'b1);
    push_word(16'h5678, 1'b0);
    run(0, 100);
    step(1'b0, 1'b1, 1'b0);
    chk("stall_inready", {15'd0, InReady}, 16'd0);
    chk("stall_out", Out, 16'h1234);
    step(1'b0, 1'b0, 1'b1);
    chk("release_out", Out, 16'h5678);
    chk("release_inready", {15'd0, InReady}, 16'd1);
    step(1'b0, 1'b0, 1'b1);

    // Reset mid-frame discards partial bits.
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b1);
    do_reset();
    step(1'b0, 1'b0, 1'b0);
    push_word(16'hFFFF, 1'b0);
    run(0, 100);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("ffff_kept", Out, 16'hFFFF);

`ifdef DEMUX16_PARITY_EN
    push_word(16'h0003, 1'b0);
    run(1, 100);
    chk("par_ok_err", {15'd0, Err}, 16'd0);
    push_word(16'h0007, 1'b0);
    run(1, 100);
    chk("par_bad_err", {15'd0, Err}, 16'd1);
    chk("par_bad_out", Out, 16'h0007);
    step(1'b0, 1'b0, 1'b1);
`endif

    // Randomized traffic: 1000 words, random InValid/OutReady.
    for (int i = 0; i < 1000; i++) begin
      w = 16'($urandom);
      push_word(w, ^w ^ ($urandom_range(7) == 0));
    end
    run(2, 90000);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
    chk("drained", {15'd0, OutValid}, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
